// File: rtl/xintf_cmd_fetch.sv
// Fetches a WORD_CNT-word frame from the XINTF write BRAM and streams it on a valid/ready port.
// Optional stale-frame skip on a repeated sequence word: define XINTF_FETCH_SEQ_CHECK_EN.
module xintf_cmd_fetch #(
   parameter int unsigned ADDR_W    = 9,
   parameter int unsigned DATA_W    = 16,
   parameter int unsigned BASE_ADDR = 0,
   parameter int unsigned WORD_CNT  = 32,
   parameter int unsigned RD_LAT    = 1
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_start,
   output logic                        o_busy,
   output logic                        o_ram_clk,
   output logic [ADDR_W-1:0]           o_ram_addr,
   output logic                        o_ram_ce,
   output logic                        o_ram_we,
   output logic [DATA_W-1:0]           o_ram_din,
   output logic                        o_ram_rst,
   input  logic [DATA_W-1:0]           i_ram_dout,
   output logic [DATA_W-1:0]           o_m_data,
   output logic [$clog2(WORD_CNT)-1:0] o_m_idx,
   output logic                        o_m_valid,
   output logic                        o_m_last,
   input  logic                        i_m_ready,
   output logic                        o_frame_done,
   output logic [15:0]                 o_frame_cnt,
   output logic                        o_stale
);

   localparam int unsigned IDX_W = $clog2(WORD_CNT);
   localparam int unsigned LAT_W = 2;
   localparam int unsigned CNT_W = 16;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORD_CNT - 1);
   localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
   localparam longint unsigned   ADDR_SPAN = 64'd1 << ADDR_W;

   // Frame must fit the address space without wrapping.
   generate
      if (64'(BASE_ADDR) + 64'(WORD_CNT) > ADDR_SPAN) begin : g_bad_range
         $error("xintf_cmd_fetch: BASE_ADDR+WORD_CNT-1 exceeds the address space");
      end
      if (WORD_CNT < 2 || RD_LAT < 1 || RD_LAT > 2) begin : g_bad_cfg
         $error("xintf_cmd_fetch: WORD_CNT must be >= 2 and RD_LAT 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_OUT, S_DONE} state_t;

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [LAT_W-1:0]    lat_q, lat_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic                busy_q, busy_d;
   logic                ce_q, ce_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                done_q, done_d;
   logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
`ifdef XINTF_FETCH_SEQ_CHECK_EN
   logic                stale_q, stale_d;
   logic [DATA_W-1:0]   word0_q, word0_d;
   logic [DATA_W-1:0]   last_seq_q, last_seq_d;
   logic                seq_valid_q, seq_valid_d;
`endif

   // Next state, counters and the registered-output images of the next state.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      lat_d       = lat_q;
      data_d      = data_q;
      frame_cnt_d = frame_cnt_q;
`ifdef XINTF_FETCH_SEQ_CHECK_EN
      stale_d     = 1'b0;
      word0_d     = word0_q;
      last_seq_d  = last_seq_q;
      seq_valid_d = seq_valid_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               state_d = S_RD;
               idx_d   = '0;
            end
         end
         S_RD: begin
            state_d = S_WAIT;
            lat_d   = LAT_W'(RD_LAT);
         end
         S_WAIT: begin
            if (lat_q == LAT_W'(1)) begin
               data_d  = i_ram_dout;
               state_d = S_OUT;
`ifdef XINTF_FETCH_SEQ_CHECK_EN
               // Word 0 carries the DSP sequence number; a repeat means nothing new to send.
               if (idx_q == '0) begin
                  word0_d = i_ram_dout;
                  if (seq_valid_q && (i_ram_dout == last_seq_q)) begin
                     state_d = S_IDLE;
                     stale_d = 1'b1;
                  end
               end
`endif
            end else begin
               lat_d = lat_q - LAT_W'(1);
            end
         end
         S_OUT: begin
            if (i_m_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d     = S_DONE;
                  frame_cnt_d = frame_cnt_q + CNT_W'(1);
               end else begin
                  idx_d   = idx_q + IDX_W'(1);
                  state_d = S_RD;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
`ifdef XINTF_FETCH_SEQ_CHECK_EN
            last_seq_d  = word0_q;
            seq_valid_d = 1'b1;
`endif
         end
         default: state_d = S_IDLE;
      endcase

      valid_d = (state_d == S_OUT);
      last_d  = valid_d && (idx_d == LAST_IDX);
      busy_d  = (state_d != S_IDLE);
      ce_d    = (state_d == S_RD);
      addr_d  = ce_d ? (BASE + ADDR_W'(idx_d)) : '0;
      done_d  = (state_d == S_DONE);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         lat_q       <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         busy_q      <= 1'b0;
         ce_q        <= 1'b0;
         addr_q      <= '0;
         done_q      <= 1'b0;
         frame_cnt_q <= '0;
`ifdef XINTF_FETCH_SEQ_CHECK_EN
         stale_q     <= 1'b0;
         word0_q     <= '0;
         last_seq_q  <= '0;
         seq_valid_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         lat_q       <= lat_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         busy_q      <= busy_d;
         ce_q        <= ce_d;
         addr_q      <= addr_d;
         done_q      <= done_d;
         frame_cnt_q <= frame_cnt_d;
`ifdef XINTF_FETCH_SEQ_CHECK_EN
         stale_q     <= stale_d;
         word0_q     <= word0_d;
         last_seq_q  <= last_seq_d;
         seq_valid_q <= seq_valid_d;
`endif
      end
   end

   assign o_busy       = busy_q;
   assign o_ram_clk    = i_clk;
   assign o_ram_addr   = addr_q;
   assign o_ram_ce     = ce_q;
   assign o_ram_we     = 1'b0;
   assign o_ram_din    = '0;
   assign o_ram_rst    = 1'b0;
   assign o_m_data     = data_q;
   assign o_m_idx      = idx_q;
   assign o_m_valid    = valid_q;
   assign o_m_last     = last_q;
   assign o_frame_done = done_q;
   assign o_frame_cnt  = frame_cnt_q;
`ifdef XINTF_FETCH_SEQ_CHECK_EN
   assign o_stale      = stale_q;
`else
   assign o_stale      = 1'b0;
`endif

endmodule

// File: tb/tb_xintf_cmd_fetch.sv
// Scoreboard bench for xintf_cmd_fetch: directed frames, ready patterns, reset abort, counter wrap,
// a RD_LAT=2 instance, and the stale-frame skip when XINTF_FETCH_SEQ_CHECK_EN is defined.
`timescale 1ns/1ps
module tb_xintf_cmd_fetch;

   localparam int unsigned AW    = 9;
   localparam int unsigned DW    = 16;
   localparam int unsigned WC    = 32;
   localparam int unsigned IW    = 5;
   localparam int unsigned WC2   = 4;
   localparam int unsigned BASE2 = 100;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [IW-1:0] idx;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1, start = 1'b0, ready = 1'b1, start2 = 1'b0, ready2 = 1'b1;
   logic          busy, ram_clk, ram_ce, ram_we, ram_rst, m_valid, m_last, frame_done, stale;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din, ram_dout = '0, m_data;
   logic [IW-1:0] m_idx;
   logic [15:0]   frame_cnt;

   logic          busy2, ram2_clk, ram2_ce, ram2_we, ram2_rst, m2_valid, m2_last, frame2_done, stale2;
   logic [AW-1:0] ram2_addr;
   logic [DW-1:0] ram2_din, ram2_p = '0, ram2_dout = '0, m2_data;
   logic [1:0]    m2_idx;
   logic [15:0]   frame2_cnt;

   logic [DW-1:0] mem [0:511];

   xintf_cmd_fetch #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(0), .WORD_CNT(WC), .RD_LAT(1)) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_ram_clk(ram_clk),
      .o_ram_addr(ram_addr), .o_ram_ce(ram_ce), .o_ram_we(ram_we), .o_ram_din(ram_din),
      .o_ram_rst(ram_rst), .i_ram_dout(ram_dout), .o_m_data(m_data), .o_m_idx(m_idx),
      .o_m_valid(m_valid), .o_m_last(m_last), .i_m_ready(ready), .o_frame_done(frame_done),
      .o_frame_cnt(frame_cnt), .o_stale(stale));

   xintf_cmd_fetch #(.ADDR_W(AW), .DATA_W(DW), .BASE_ADDR(BASE2), .WORD_CNT(WC2), .RD_LAT(2)) dut2 (
      .i_clk(clk), .i_rst(rst), .i_start(start2), .o_busy(busy2), .o_ram_clk(ram2_clk),
      .o_ram_addr(ram2_addr), .o_ram_ce(ram2_ce), .o_ram_we(ram2_we), .o_ram_din(ram2_din),
      .o_ram_rst(ram2_rst), .i_ram_dout(ram2_dout), .o_m_data(m2_data), .o_m_idx(m2_idx),
      .o_m_valid(m2_valid), .o_m_last(m2_last), .i_m_ready(ready2), .o_frame_done(frame2_done),
      .o_frame_cnt(frame2_cnt), .o_stale(stale2));

   // BRAM models: one-cycle read for dut, registered-output two-cycle read for dut2.
   always @(posedge ram_clk) if (ram_ce) ram_dout <= mem[ram_addr];
   always @(posedge ram2_clk) begin
      if (ram2_ce) ram2_p <= mem[ram2_addr];
      ram2_dout <= ram2_p;
   end

   int total = 0, bad = 0;
   int cyc = 0, beats = 0, done_cnt = 0, stale_cnt = 0;
   int rmode = 0, rphase = 0;
   logic [15:0] exp_cnt = '0;
   beat_t exp_q[$];

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Ready patterns: 0 tied high, 1 toggling, 2 five-low / three-high bursts.
   always @(posedge clk) begin
      #1;
      rphase++;
      case (rmode)
         1:       ready = rphase[0];
         2:       ready = (rphase % 8) >= 5;
         default: ready = 1'b1;
      endcase
   end

   // Monitor: pops the scoreboard on every handshake, checks hold-while-stalled and no reads in OUT.
   logic [DW-1:0] held_data;
   logic [IW-1:0] held_idx;
   logic          held = 1'b0;
   always @(negedge clk) begin
      beat_t e;
      if (m_valid) begin
         chk("ce_during_out", 32'(ram_ce), 32'd0);
         if (held) begin
            chk("hold_data", 32'(m_data), 32'(held_data));
            chk("hold_idx", 32'(m_idx), 32'(held_idx));
         end
         if (ready) begin
            beats++;
            held = 1'b0;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat: got data 0x%0h idx %0d, none expected", m_data, m_idx);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", 32'(m_data), 32'(e.data));
               chk("beat_idx", 32'(m_idx), 32'(e.idx));
               chk("beat_last", 32'(m_last), 32'(e.last));
            end
         end else begin
            held      = 1'b1;
            held_data = m_data;
            held_idx  = m_idx;
         end
      end else begin
         held = 1'b0;
      end
      if (frame_done) done_cnt++;
      if (stale) stale_cnt++;
   end

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
   endtask

   task automatic wait_done(input int c0, input int limit, output int rel);
      bit got = 1'b0;
      rel = -1;
      for (int n = 0; n < limit; n++) begin
         @(negedge clk);
         if (frame_done) begin
            got = 1'b1;
            rel = cyc - c0;
            break;
         end
      end
      if (!got) begin
         total++;
         bad++;
         $display("FAIL done_timeout: no frame_done within %0d cycles", limit);
      end
   endtask

   // One full frame with mem[i] = pat+i; optionally checks the ready-tied-high timing.
   task automatic run_frame(input int mode, input logic [15:0] pat, input bit timing);
      int c0, rel;
      beat_t e;
      for (int i = 0; i < int'(WC); i++) begin
         mem[i]  = pat + 16'(i);
         e.data  = pat + 16'(i);
         e.idx   = IW'(i);
         e.last  = (i == int'(WC) - 1);
         exp_q.push_back(e);
      end
      rmode = mode;
      @(posedge clk); #1;
      start = 1'b1;
      c0 = cyc;
      @(negedge clk);
      chk("busy_rel0", 32'(busy), 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("busy_rel1", 32'(busy), 32'd1);
      chk("ce_rel1", 32'(ram_ce), 32'd1);
      chk("addr_rel1", 32'(ram_addr), 32'd0);
      wait_done(c0, 3000, rel);
      exp_cnt = exp_cnt + 16'd1;
      if (timing) chk("done_cycle", 32'(rel), 32'd97);
      chk("busy_at_done", 32'(busy), 32'd1);
      chk("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(frame_done), 32'd0);
      rmode = 0;
   endtask

   initial begin
      int c0, rel, d0, b0, s0;
      int ce_rel, valid_rel, done_rel, k;
      logic [AW-1:0] first_addr;

      for (int i = 0; i < 512; i++) mem[i] = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_ce", 32'(ram_ce), 32'd0);
      chk("rst_addr", 32'(ram_addr), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
      chk("rst_cnt", 32'(frame_cnt), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_stale", 32'(stale), 32'd0);
      chk("rst_we_din_rst", {15'd0, ram_we, ram_din}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_frame(0, 16'h1000, 1'b1);
      do_reset();
      run_frame(1, 16'h1000, 1'b0);
      do_reset();
      run_frame(2, 16'h1000, 1'b0);

      // Starts while busy are dropped.
      do_reset();
      for (int i = 0; i < int'(WC); i++) begin
         beat_t e;
         mem[i] = 16'h3000 + 16'(i);
         e.data = 16'h3000 + 16'(i);
         e.idx  = IW'(i);
         e.last = (i == int'(WC) - 1);
         exp_q.push_back(e);
      end
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (44) @(posedge clk);
      #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(c0, 3000, rel);
      chk("multi_start_done_cycle", 32'(rel), 32'd97);
      repeat (150) @(negedge clk);
      chk("multi_start_one_frame", 32'(done_cnt - d0), 32'd1);
      chk("multi_start_cnt", 32'(frame_cnt), 32'd1);
      chk("multi_start_idle", 32'(busy), 32'd0);

      // Reset at beat 10 aborts the frame.
      for (int i = 0; i < int'(WC); i++) mem[i] = 16'h4000 + 16'(i);
      exp_q.delete();
      for (int i = 0; i <= 10; i++) begin
         beat_t e;
         e.data = 16'h4000 + 16'(i);
         e.idx  = IW'(i);
         e.last = 1'b0;
         exp_q.push_back(e);
      end
      d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      k = 0;
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         if (m_valid && m_idx == IW'(10)) begin
            k = 1;
            break;
         end
      end
      if (k == 0) begin
         total++;
         bad++;
         $display("FAIL beat10_timeout: beat 10 not reached");
      end
      rst = 1'b1;
      @(negedge clk);
      chk("abort_valid", 32'(m_valid), 32'd0);
      chk("abort_cnt", 32'(frame_cnt), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      exp_q.delete();
      exp_cnt = '0;
      repeat (5) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_frame(0, 16'h5A00, 1'b1);

      // Frame counter wraps.
      do_reset();
      force dut.frame_cnt_q = 16'hFFFF;
      @(negedge clk);
      chk("cnt_forced", 32'(frame_cnt), 32'h0000FFFF);
      release dut.frame_cnt_q;
      exp_cnt = 16'hFFFF;
      run_frame(0, 16'h6000, 1'b0);
      chk("cnt_wrapped", 32'(frame_cnt), 32'd0);

      // RD_LAT=2 instance: address at 1, valid at 4, done at 1+4*4.
      do_reset();
      for (int i = 0; i < int'(WC2); i++) mem[BASE2 + i] = 16'hB000 + 16'(i);
      ce_rel = -1; valid_rel = -1; done_rel = -1; k = 0; first_addr = '0;
      @(posedge clk); #1;
      start2 = 1'b1;
      c0 = cyc;
      @(posedge clk); #1;
      start2 = 1'b0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (ram2_ce && ce_rel < 0) begin
            ce_rel = cyc - c0;
            first_addr = ram2_addr;
         end
         if (m2_valid) begin
            if (valid_rel < 0) valid_rel = cyc - c0;
            chk("lat2_data", 32'(m2_data), 32'(16'hB000 + 16'(k)));
            chk("lat2_idx", 32'(m2_idx), 32'(k));
            chk("lat2_last", 32'(m2_last), 32'(k == int'(WC2) - 1));
            k++;
         end
         if (frame2_done) begin
            done_rel = cyc - c0;
            break;
         end
      end
      chk("lat2_addr_cycle", 32'(ce_rel), 32'd1);
      chk("lat2_first_addr", 32'(first_addr), 32'(BASE2));
      chk("lat2_valid_cycle", 32'(valid_rel), 32'd4);
      chk("lat2_done_cycle", 32'(done_rel), 32'd17);
      chk("lat2_beats", 32'(k), 32'(WC2));
      chk("lat2_cnt", 32'(frame2_cnt), 32'd1);

`ifdef XINTF_FETCH_SEQ_CHECK_EN
      do_reset();
      run_frame(0, 16'h0007, 1'b1);
      s0 = stale_cnt; b0 = beats; d0 = done_cnt;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (20) @(negedge clk);
      chk("seq_stale_pulse", 32'(stale_cnt - s0), 32'd1);
      chk("seq_no_beats", 32'(beats - b0), 32'd0);
      chk("seq_no_done", 32'(done_cnt - d0), 32'd0);
      chk("seq_cnt_held", 32'(frame_cnt), 32'd1);
      chk("seq_idle", 32'(busy), 32'd0);
      run_frame(0, 16'h0008, 1'b1);
      chk("seq_cnt2", 32'(frame_cnt), 32'd2);
`else
      chk("stale_never", 32'(stale_cnt), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/xintf_cmd_fetch.md
# xintf_cmd_fetch

Frame fetcher on the PL side of the DSP XINTF write RAM (the dual-port BRAM the DSP fills through the XINTF bridge). On a start pulse it reads a fixed block of WORD_CNT 16-bit words through the BRAM's second port. It emits them one at a time on a valid/ready stream to the downstream command decoder, then pulses frame-done. It also drives the port pins the BRAM expects (clk, en, we, din, rst) so the port can be connected directly.

## Interface
Parameters:
- ADDR_W, 9, BRAM address width (matches 9-bit XINTF address space)
- DATA_W, 16, word width
- BASE_ADDR, 0, first word address of the frame
- WORD_CNT, 32, words per frame (≥2); BASE_ADDR+WORD_CNT-1 ≤ 2^ADDR_W-1 (no address wrap, elaboration-time check)
- RD_LAT, 1, BRAM read latency in cycles (1 or 2)

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock, also forwarded to the BRAM port
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  single-cycle frame request; ignored while o_busy=1
- o_busy  out  1  high from the cycle after an accepted start through the DONE cycle
- o_ram_clk  out  1  = i_clk
- o_ram_addr  out  ADDR_W  BASE_ADDR+idx during RD, else 0
- o_ram_ce  out  1  high only in RD
- o_ram_we  out  1  constant 0
- o_ram_din  out  DATA_W  constant 0
- o_ram_rst  out  1  constant 0
- i_ram_dout  in  DATA_W  BRAM read data
- o_m_data  out  DATA_W  registered word
- o_m_idx  out  $clog2(WORD_CNT)  word index within the frame
- o_m_valid  out  1  word available
- o_m_last  out  1  o_m_valid && idx==WORD_CNT-1
- i_m_ready  in  1  consumer accepts the word
- o_frame_done  out  1  one-cycle pulse on frame completion
- o_frame_cnt  out  16  completed frames; wraps 0xFFFF→0x0000
- o_stale  out  1  one-cycle pulse when a frame is skipped (see Configuration)

## Operation
- FSM states: IDLE, RD, WAIT, OUT, DONE.
- IDLE
  - i_start=1 → RD; idx=0.
- RD (1 cycle)
  - o_ram_ce=1, o_ram_addr=BASE_ADDR+idx.
  - → WAIT; latency counter = RD_LAT.
- WAIT
  - Count down RD_LAT cycles.
  - On the last cycle, register i_ram_dout into o_m_data → OUT.
- OUT
  - o_m_valid=1; o_m_data and o_m_idx hold stable until the handshake.
  - Handshake is o_m_valid && i_m_ready. On handshake:
    - idx==WORD_CNT-1 → DONE.
    - Otherwise idx+1 → RD.
- DONE (1 cycle)
  - o_frame_done=1, o_frame_cnt+1 → IDLE.
- i_start in any state other than IDLE is dropped. It is not queued.
- Reset values: state IDLE; all outputs 0 except o_ram_clk. o_frame_cnt=0; internal seq_valid=0.
- Reset mid-frame: abort at the next edge. No o_frame_done, o_frame_cnt=0, o_m_valid falls immediately.
- Ready held low: stall indefinitely in OUT. No further BRAM reads are issued.
- DSP writes during a fetch are not guarded. Frame coherency is the DSP's responsibility (sequence word, see Configuration).

## Timing
- Start sampled at cycle 0 → RD at cycle 1.
- Word k address is presented at cycle 1+k·(RD_LAT+2) when ready is tied high.
- Data is sampled at the end of cycle (address cycle + RD_LAT); o_m_valid rises the next cycle.
- Throughput with ready tied high: RD_LAT+2 cycles/word.
  - Example, RD_LAT=1, WORD_CNT=32: o_frame_done at cycle 97; o_busy high in cycles 1–97.
- Next start is accepted at the earliest in the cycle after DONE.

## Configuration
- XINTF_FETCH_SEQ_CHECK_EN defined:
  - Word 0 is the DSP sequence number.
  - After word 0 is captured:
    - If seq_valid=1 and word0==last_seq: skip the frame. No stream beat, o_stale pulses one cycle, o_frame_cnt unchanged, → IDLE.
    - Otherwise stream normally.
  - On DONE: last_seq=word0, seq_valid=1.
- Not defined: every frame streams, o_stale is tied 0, and no sequence register is built.

## Test plan
- Reset, RD_LAT=1, WORD_CNT=32, RAM[i]=0x1000+i, ready=1, start at cycle 0 → 32 beats 0x1000..0x101F, idx 0..31, o_m_last only on beat 31, o_frame_done at cycle 97, o_frame_cnt=1.
- Same frame with i_m_ready toggling 1/0 every cycle (and 5-cycle ready-low bursts) → identical data/idx order; data stable while valid && !ready; o_ram_ce never high during OUT.
- RD_LAT=2 → word 0 address cycle 1, valid cycle 4; done at cycle 1+32·4=129.
- i_start pulsed at cycles 0, 5, 50 → only one frame; o_frame_cnt=1. Then i_rst asserted mid-frame at beat 10 → o_m_valid=0 next cycle, no done pulse, o_frame_cnt=0, next start fetches from idx 0.
- XINTF_FETCH_SEQ_CHECK_EN, word0=0x0007 → frame 1 streams. Frame 2 unchanged → o_stale pulse, zero beats, o_frame_cnt=1. DSP writes word0=0x0008 → frame 3 streams, o_frame_cnt=2.
- Force o_frame_cnt to 0xFFFF, then complete a frame → o_frame_cnt=0x0000.
